// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - instruction word array with byte-serial program loader and core reset hold
module inst_rom_loader #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [7:0]  ld_byte_i,
    input  logic        ld_last_i,
    input  logic        reload_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_o,
    output logic        cpu_rst_n_o,
    output logic        load_done_o,
    output logic        load_err_o
);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] WPTR_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [0:0]            state_q, state_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [DEPTH_LOG2:0]   wptr_q, wptr_d;
    logic [23:0]           shreg_q, shreg_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic                  load_err_q, load_err_d;

    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  word_we;
    logic                  full;
    logic                  mem_we;
    logic [31:0]           word;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  upper_ok;

    assign ld_ready_o  = (state_q == ST_LOAD);
    assign load_done_o = (state_q == ST_RUN);
    assign cpu_rst_n_o = cpu_rst_n_q;
    assign load_err_o  = load_err_q;

    assign accept  = ld_valid_i & ld_ready_o;
    // Unfilled upper lanes are already zero because shreg is cleared after each write.
    assign word    = {8'b0, shreg_q} | ({24'b0, ld_byte_i} << {bcnt_q, 3'b000});
    assign word_we = accept & ((bcnt_q == 2'd3) | ld_last_i);
    assign full    = (wptr_q == WPTR_MAX);
    assign mem_we  = word_we & ~full & rst_n;

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        wptr_d      = wptr_q;
        shreg_d     = shreg_q;
        cpu_rst_n_d = cpu_rst_n_q;
        load_err_d  = load_err_q;
        if (reload_i && state_q == ST_RUN) begin
            state_d     = ST_LOAD;
            bcnt_d      = 2'd0;
            wptr_d      = '0;
            shreg_d     = '0;
            cpu_rst_n_d = 1'b0;
            load_err_d  = 1'b0;
        end else if (accept) begin
            if (word_we) begin
                shreg_d = '0;
                bcnt_d  = 2'd0;
                if (full) begin
                    load_err_d = 1'b1;
                end else begin
                    wptr_d = wptr_q + 1'b1;
                end
            end else begin
                shreg_d = word[23:0];
                bcnt_d  = bcnt_q + 2'd1;
            end
            if (ld_last_i) begin
                state_d     = ST_RUN;
                cpu_rst_n_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            bcnt_q      <= 2'd0;
            wptr_q      <= '0;
            shreg_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            wptr_q      <= wptr_d;
            shreg_q     <= shreg_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            load_err_q  <= load_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q[DEPTH_LOG2-1:0]] <= word;
        end
    end

    assign idx = inst_addr_i[DEPTH_LOG2+1:2];

    generate
        if (DEPTH_LOG2 >= 30) begin : g_no_upper
            assign upper_ok = 1'b1;
        end else begin : g_upper
            assign upper_ok = (inst_addr_i[31:DEPTH_LOG2+2] == '0);
        end
    endgenerate

    always_comb begin
        inst_o = NOP_INST;
        if (state_q == ST_RUN && inst_addr_i[1:0] == 2'b00 && upper_ok
            && ({1'b0, idx} < wptr_q)) begin
            inst_o = mem[idx];
        end
    end

endmodule
